// File: rtl/credit_pkg.sv
// ---------------------------------------------------------------------------
// credit_pkg
// Shared types and helpers for the credit-based push link (transmit side and
// any future receive side).
//   credit_tx_state_e : transmit FSM states (RUN accepts traffic, DRAIN waits
//                       for every outstanding credit to come home)
//   cnt_width(n)      : bits needed to hold a count in the range 0..n
// ---------------------------------------------------------------------------
package credit_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } credit_tx_state_e;

   // Width of a counter that must represent every value from 0 to n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/credit_counter.sv
// ---------------------------------------------------------------------------
// credit_counter
// Saturating up/down counter holding free remote slots. Resets and clears to
// MAX (all slots free).
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i        : one credit returned this cycle
//   dec_i        : one credit consumed this cycle
//   clr_i        : restore count to MAX; inc_i/dec_i ignored this cycle
//   count_o      : current count
//   zero_o       : count == 0
//   max_o        : count == MAX
//   ovf_o        : a lone inc_i arrived while count == MAX (count holds)
// ---------------------------------------------------------------------------
module credit_counter #(
   parameter int unsigned MAX = 8,
   parameter int unsigned W   = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o,
   output logic         zero_o,
   output logic         max_o,
   output logic         ovf_o
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: simultaneous inc/dec cancel; both ends saturate.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = MAX_V;
      end else if (inc_i && !dec_i && (count_q != MAX_V)) begin
         count_d = count_q + W'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= MAX_V;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);
   assign max_o   = (count_q == MAX_V);
   assign ovf_o   = inc_i & ~dec_i & ~clr_i & (count_q == MAX_V);

endmodule

// File: rtl/credit_push_tx.sv
// ---------------------------------------------------------------------------
// credit_push_tx
// Transmit side of a credit-based link into a remote push/pop FIFO whose full
// flag cannot be observed in time. A local credit count mirrors the free
// remote slots; the remote end returns one credit per pop.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : abort, coincident with the remote FIFO flush
//   valid_i      : upstream data valid
//   ready_o      : upstream may transfer (combinational, independent of valid_i)
//   data_i       : upstream payload
//   push_o       : registered push into the remote FIFO
//   data_o       : registered payload into the remote FIFO
//   credit_i     : one credit returned per cycle high
//   drain_i      : stop accepting and wait for all credits to return
//   drained_o    : single-cycle pulse when a drain completes
//   credits_o    : current credit count
//   err_o        : sticky, credit returned while the count was already full
// ---------------------------------------------------------------------------
module credit_push_tx
   import credit_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned CREDITS    = 8,
   parameter  type         dtype      = logic [DATA_WIDTH-1:0],
   localparam int unsigned CNT_W      = cnt_width(CREDITS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  dtype             data_i,
   output logic             push_o,
   output dtype             data_o,
   input  logic             credit_i,
   input  logic             drain_i,
   output logic             drained_o,
   output logic [CNT_W-1:0] credits_o,
   output logic             err_o
);

   credit_tx_state_e state_q, state_d;
   logic             push_q,  push_d;
   dtype             data_q,  data_d;
   logic             err_q,   err_d;

   logic             cnt_zero;
   logic             cnt_max;
   logic             cnt_ovf;
   logic             accept;
   logic             drain_done;

   // Flush restores the full credit count and discards any credit in that cycle.
   credit_counter #(
      .MAX (CREDITS),
      .W   (CNT_W)
   ) u_credit_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (credit_i),
      .dec_i   (accept),
      .clr_i   (flush_i),
      .count_o (credits_o),
      .zero_o  (cnt_zero),
      .max_o   (cnt_max),
      .ovf_o   (cnt_ovf)
   );

   assign ready_o = (state_q == RUN) & ~cnt_zero & ~flush_i;
   assign accept  = valid_i & ready_o;

   // Drain is complete once every credit is home and nothing is on the wire.
   assign drain_done = (state_q == DRAIN) & cnt_max & ~push_q;
   assign drained_o  = drain_done & ~flush_i;

   // Next-state and output-register logic; flush overrides everything below.
   always_comb begin
      state_d = state_q;
      push_d  = accept;
      data_d  = data_q;
      err_d   = err_q | cnt_ovf;

      if (accept) begin
         data_d = data_i;
      end

      case (state_q)
         RUN:   if (drain_i)    state_d = DRAIN;
         DRAIN: if (drain_done) state_d = RUN;
      endcase

      if (flush_i) begin
         state_d = RUN;
         push_d  = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         push_q  <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         push_q  <= push_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign push_o = push_q;
   assign data_o = data_q;
   assign err_o  = err_q;

endmodule
